// File: rtl/cc_displaytimer_ticker.sv
// Programmable display/game timer: counter, loadable terminal value,
// periodic or one-shot mode, pause/clear control, active-low tick.
module cc_displaytimer_ticker #(
  parameter int DATAWIDTH = 27,
  parameter logic [DATAWIDTH-1:0] DEFAULT_LIMIT = 27'd99_999_999
) (
  input  logic                 CC_DISPLAYTIMER_TICKER_CLOCK_50,
  input  logic                 CC_DISPLAYTIMER_TICKER_RESET_InHigh,
  input  logic                 CC_DISPLAYTIMER_TICKER_start_InHigh,
  input  logic                 CC_DISPLAYTIMER_TICKER_enable_InHigh,
  input  logic                 CC_DISPLAYTIMER_TICKER_clear_InHigh,
  input  logic                 CC_DISPLAYTIMER_TICKER_load_InHigh,
  input  logic [DATAWIDTH-1:0] CC_DISPLAYTIMER_TICKER_limit_InBUS,
  input  logic                 CC_DISPLAYTIMER_TICKER_oneshot_InHigh,
  output logic                 CC_DISPLAYTIMER_TICKER_tick_OutLow,
  output logic                 CC_DISPLAYTIMER_TICKER_done_OutHigh,
  output logic                 CC_DISPLAYTIMER_TICKER_busy_OutHigh,
  output logic [DATAWIDTH-1:0] CC_DISPLAYTIMER_TICKER_count_OutBUS
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } stateT;

  localparam logic [DATAWIDTH-1:0] ONE = {{(DATAWIDTH-1){1'b0}}, 1'b1};

  stateT                state;
  stateT                nState;
  logic [DATAWIDTH-1:0] count;
  logic [DATAWIDTH-1:0] nCount;
  logic [DATAWIDTH-1:0] limitReg;
  logic                 nTick;
  logic                 tickReg;
  logic                 doneReg;
  logic                 busyReg;

  // Next state/count; a paused count resumes counting on the enable cycle
  always_comb begin
    nState = state;
    nCount = count;
    nTick  = 1'b1;
    if (CC_DISPLAYTIMER_TICKER_start_InHigh) begin
      nState = RUN;
      nCount = '0;
    end else begin
      case (state)
        RUN, PAUSE: begin
          if (!CC_DISPLAYTIMER_TICKER_enable_InHigh) begin
            nState = PAUSE;
          end else if (count >= limitReg) begin
            nCount = '0;
            nTick  = 1'b0;
            nState = CC_DISPLAYTIMER_TICKER_oneshot_InHigh ? DONE : RUN;
          end else begin
            nCount = count + ONE;
            nState = RUN;
          end
        end
        default: nCount = '0;
      endcase
    end
  end

  // State, count, limit and registered output decodes
  always_ff @(posedge CC_DISPLAYTIMER_TICKER_CLOCK_50) begin
    if (CC_DISPLAYTIMER_TICKER_RESET_InHigh) begin
      state    <= IDLE;
      count    <= '0;
      limitReg <= DEFAULT_LIMIT;
      tickReg  <= 1'b1;
      doneReg  <= 1'b0;
      busyReg  <= 1'b0;
    end else if (CC_DISPLAYTIMER_TICKER_clear_InHigh) begin
      state    <= IDLE;
      count    <= '0;
      tickReg  <= 1'b1;
      doneReg  <= 1'b0;
      busyReg  <= 1'b0;
    end else begin
      state   <= nState;
      count   <= nCount;
      tickReg <= nTick;
      doneReg <= (nState == DONE);
      busyReg <= (nState == RUN) || (nState == PAUSE);
      if (CC_DISPLAYTIMER_TICKER_load_InHigh)
        limitReg <= CC_DISPLAYTIMER_TICKER_limit_InBUS;
    end
  end

  assign CC_DISPLAYTIMER_TICKER_tick_OutLow  = tickReg;
  assign CC_DISPLAYTIMER_TICKER_done_OutHigh = doneReg;
  assign CC_DISPLAYTIMER_TICKER_busy_OutHigh = busyReg;
  assign CC_DISPLAYTIMER_TICKER_count_OutBUS = count;

endmodule

// File: doc/cc_displaytimer_ticker.md
Name: cc_displaytimer_ticker

Overview:
- Programmable display/game timer that replaces the fixed free-running counter plus fixed compare-value pair with one block.
- Owns its counter, a runtime-loadable terminal value, periodic or one-shot mode, and pause/clear control.
- Emits a one-cycle active-low tick at each terminal count.
- Sits between the 50 MHz clock domain and the game FSM and display logic, for example level-dependent lane speed and round timeout.

Parameters:
- DATAWIDTH, 27, width of counter and limit.
- DEFAULT_LIMIT, 27'd99_999_999, terminal value loaded at reset (2 s period at 50 MHz).

Ports:
- CC_DISPLAYTIMER_TICKER_CLOCK_50  in  1  system clock; all logic on rising edge.
- CC_DISPLAYTIMER_TICKER_RESET_InHigh  in  1  synchronous reset, active-high.
- CC_DISPLAYTIMER_TICKER_start_InHigh  in  1  pulse; (re)start counting from 0.
- CC_DISPLAYTIMER_TICKER_enable_InHigh  in  1  level; 0 pauses a running count.
- CC_DISPLAYTIMER_TICKER_clear_InHigh  in  1  pulse; abort and return to IDLE.
- CC_DISPLAYTIMER_TICKER_load_InHigh  in  1  pulse; capture limit_InBUS.
- CC_DISPLAYTIMER_TICKER_limit_InBUS  in  DATAWIDTH  new terminal value.
- CC_DISPLAYTIMER_TICKER_oneshot_InHigh  in  1  mode: 1 = one-shot, 0 = periodic; sampled at each terminal event.
- CC_DISPLAYTIMER_TICKER_tick_OutLow  out  1  registered one-cycle low pulse at terminal count.
- CC_DISPLAYTIMER_TICKER_done_OutHigh  out  1  high while in DONE (one-shot expired).
- CC_DISPLAYTIMER_TICKER_busy_OutHigh  out  1  high in RUN or PAUSE.
- CC_DISPLAYTIMER_TICKER_count_OutBUS  out  DATAWIDTH  current count.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE, count=0, limit_reg=DEFAULT_LIMIT.
  - tick_OutLow=1, done=0, busy=0.
- Priority within a cycle: reset > clear > load > start > enable/count.
  - load is not exclusive; it combines with start and counting in the same cycle.
- States:
  - IDLE: count held at 0. start -> RUN, count=0.
  - RUN:
    - enable=0 -> PAUSE; count holds at its current value.
    - enable=1, count < limit_reg -> count+1.
    - enable=1, count >= limit_reg (terminal) -> count=0 and tick_OutLow=0 on the next cycle only.
    - At terminal, periodic mode stays in RUN; one-shot mode goes to DONE.
  - PAUSE: count frozen, no ticks. enable=1 -> RUN and resumes from the frozen count. start -> RUN, count=0.
  - DONE: count=0, done=1. start -> RUN, count=0, done=0.
- Any state, start asserted: restart RUN from count=0; no tick is generated by the restart.
- clear: state=IDLE, count=0, done=0, tick_OutLow=1 next cycle; limit_reg is kept.
- load:
  - limit_reg=limit_InBUS next cycle. A terminal compare in the same cycle uses the old limit.
  - Terminal test is >=, so a new limit below the current count causes a terminal event on the next RUN cycle; the counter never runs away.
- Period: limit_reg+1 clock cycles between tick pulses in periodic mode.
  - limit_reg=0 gives tick_OutLow held low every RUN cycle.
- Counter never exceeds limit_reg, so there is no wrap-around of count; the maximum limit is 2^DATAWIDTH-1.
- tick_OutLow is registered, so it is high in every cycle except the one after a terminal event. done and busy are registered decodes of the state.

Test Plan:
- DATAWIDTH=8, DEFAULT_LIMIT=4: reset, start, enable=1, periodic -> count 0,1,2,3,4,0...; tick_OutLow low exactly one cycle every 5 cycles; busy=1, done=0.
- One-shot=1, start -> count reaches 4, single tick, then done=1, busy=0, count=0; no further ticks. A second start clears done and repeats.
- Periodic run with enable dropped at count=2 for 10 cycles -> count frozen at 2, no tick. enable=1 -> resumes 3,4, then tick; total period 15 cycles.
- load limit=1 while count=3 (old limit 4) -> next RUN cycle is terminal (tick), then period is 2 cycles. Load and terminal in the same cycle -> the tick still uses the old limit.
- clear during RUN at count=3, with start asserted in the same cycle -> IDLE, count=0, no tick, busy=0 (clear wins). Reset asserted mid-run -> all outputs return to reset values next edge and limit_reg=4.
- load limit=0, start -> tick_OutLow low continuously while RUN. limit=255, start -> first tick after 256 cycles, count never exceeds 255.
